// File: rtl/sap_bus_arbiter.sv
// Round-robin arbiter for the shared W-bus: one-hot grants with a per-tenure hold
// limit and a forced all-low turnaround gap so no two bus drivers ever overlap.
module sap_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic               inCLK,
    input  logic               inReset,
    input  logic [NUM_REQ-1:0] inReq,
    output logic [NUM_REQ-1:0] outGrant,
    output logic [2:0]         outOwner,
    output logic               outBusy,
    output logic               outTimeout
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         hold_reg, hold_next;
    logic [3:0]         turn_reg, turn_next;
    logic [2:0]         last_reg, last_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [2:0]         owner_reg, owner_next;
    logic               busy_reg, busy_next;
    logic               timeout_reg, timeout_next;

    logic [3:0]         arb_start;
    logic [NUM_REQ-1:0] req_rot;
    logic               arb_found;
    logic [3:0]         arb_offset;
    logic [3:0]         arb_sum;
    logic [2:0]         arb_idx;
    logic [NUM_REQ-1:0] arb_onehot;
    logic               owner_req;
    logic               hold_at_max;
    logic               turn_done;

    // Rotate requests so bit 0 is the requester just after the last owner.
    assign arb_start = {1'b0, last_reg} + 4'd1;
    assign req_rot   = NUM_REQ'({inReq, inReq} >> arb_start);

    always_comb begin
        arb_found  = 1'b0;
        arb_offset = 4'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_found && req_rot[j]) begin
                arb_found  = 1'b1;
                arb_offset = 4'(j);
            end
        end
        arb_sum = arb_start + arb_offset;
        if (arb_sum >= 4'(NUM_REQ))
            arb_sum = arb_sum - 4'(NUM_REQ);
        arb_idx = arb_sum[2:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign arb_onehot[gi] = arb_found && (arb_idx == 3'(gi));
        end
    endgenerate

    assign owner_req   = |(grant_reg & inReq);
    assign hold_at_max = (hold_reg == 8'(MAX_HOLD));
    assign turn_done   = (turn_reg == 4'(TURN_CYCLES));

    always_ff @(posedge inCLK) begin
        if (inReset) begin
            state_reg   <= IDLE;
            hold_reg    <= 8'd0;
            turn_reg    <= 4'd0;
            last_reg    <= 3'(NUM_REQ - 1);
            grant_reg   <= '0;
            owner_reg   <= 3'd0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            turn_reg    <= turn_next;
            last_reg    <= last_next;
            grant_reg   <= grant_next;
            owner_reg   <= owner_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        turn_next  = turn_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next = GRANT;
                    hold_next  = 8'd1;
                end
            end
            GRANT: begin
                // A dropped request wins over the hold limit, so no timeout then.
                if (!owner_req || hold_at_max) begin
                    state_next = TURN;
                    hold_next  = 8'd0;
                    turn_next  = 4'd1;
                    last_next  = owner_reg;
                end else begin
                    hold_next = hold_reg + 8'd1;
                end
            end
            TURN: begin
                if (turn_done) begin
                    turn_next = 4'd0;
                    if (arb_found) begin
                        state_next = GRANT;
                        hold_next  = 8'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    turn_next = turn_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_next   = '0;
        owner_next   = 3'd0;
        busy_next    = 1'b0;
        timeout_next = (state_reg == GRANT) && owner_req && hold_at_max;
        if (state_next == GRANT) begin
            busy_next = 1'b1;
            if (state_reg == GRANT) begin
                grant_next = grant_reg;
                owner_next = owner_reg;
            end else begin
                grant_next = arb_onehot;
                owner_next = arb_idx;
            end
        end
    end

    assign outGrant   = grant_reg;
    assign outOwner   = owner_reg;
    assign outBusy    = busy_reg;
    assign outTimeout = timeout_reg;

endmodule

// File: tb/tb_sap_bus_arbiter.sv
// Directed bench for sap_bus_arbiter: four instances with different hold/turn settings
// share one request/reset stimulus; each scenario checks the instance it targets.
module tb_sap_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant [4];
    logic [2:0] owner [4];
    logic       busy  [4];
    logic       tmo   [4];
    logic [3:0] prev_grant [4];

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    // 0: hold 8 / turn 1, 1: hold 2 / turn 1, 2: hold 8 / turn 3, 3: hold 4 / turn 1
    sap_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) u_a (
        .inCLK(clk), .inReset(rst), .inReq(req),
        .outGrant(grant[0]), .outOwner(owner[0]), .outBusy(busy[0]), .outTimeout(tmo[0]));
    sap_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(2), .TURN_CYCLES(1)) u_b (
        .inCLK(clk), .inReset(rst), .inReq(req),
        .outGrant(grant[1]), .outOwner(owner[1]), .outBusy(busy[1]), .outTimeout(tmo[1]));
    sap_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(3)) u_c (
        .inCLK(clk), .inReset(rst), .inReq(req),
        .outGrant(grant[2]), .outOwner(owner[2]), .outBusy(busy[2]), .outTimeout(tmo[2]));
    sap_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .TURN_CYCLES(1)) u_d (
        .inCLK(clk), .inReset(rst), .inReq(req),
        .outGrant(grant[3]), .outOwner(owner[3]), .outBusy(busy[3]), .outTimeout(tmo[3]));

    // Bus-safety invariants on every instance, sampled on the falling edge.
    initial for (int i = 0; i < 4; i++) prev_grant[i] = 4'd0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (!$onehot0(grant[i]) || (busy[i] !== (|grant[i])) ||
                (prev_grant[i] != 4'd0 && grant[i] != 4'd0 && grant[i] != prev_grant[i])) begin
                $display("FAIL invariant inst%0d: grant=%b busy=%b prev=%b", i, grant[i], busy[i], prev_grant[i]);
            end else begin
                pass_cnt++;
            end
            prev_grant[i] = grant[i];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Observed vector is {grant, owner, busy, timeout}.
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if ({grant[i], owner[i], busy[i], tmo[i]} !== 9'b0000_000_0_0) begin
                $display("FAIL reset inst%0d: got g=%b o=%0d b=%b t=%b, want all zero", i, grant[i], owner[i], busy[i], tmo[i]);
            end else pass_cnt++;
            $display("reset inst%0d g=%b o=%0d", i, grant[i], owner[i]);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_cnt++;
            if ({grant[0], owner[0], busy[0], tmo[0]} !== {4'b0001, 3'd0, 1'b1, 1'b0}) begin
                $display("FAIL single cyc%0d: got g=%b o=%0d b=%b t=%b, want g=0001 o=0 b=1 t=0", c, grant[0], owner[0], busy[0], tmo[0]);
            end else pass_cnt++;
            $display("single cyc%0d g=%b b=%b t=%b", c, grant[0], busy[0], tmo[0]);
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            check_cnt++;
            if ({grant[0], owner[0], busy[0], tmo[0]} !== 9'b0000_000_0_0) begin
                $display("FAIL single_release cyc%0d: got g=%b b=%b t=%b, want zero", c, grant[0], busy[0], tmo[0]);
            end else pass_cnt++;
            $display("single_release cyc%0d g=%b", c, grant[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            exp_g = 4'b0001 << (o % 4);
            for (int c = 0; c < 2; c++) begin
                tick();
                check_cnt++;
                if ({grant[1], owner[1], busy[1], tmo[1]} !== {exp_g, 3'(o % 4), 1'b1, 1'b0}) begin
                    $display("FAIL rr_grant o%0d c%0d: got g=%b o=%0d t=%b, want g=%b o=%0d t=0", o, c, grant[1], owner[1], tmo[1], exp_g, o % 4);
                end else pass_cnt++;
                $display("rr owner%0d cyc%0d g=%b", o % 4, c, grant[1]);
            end
            if (o < 4) begin
                tick();
                check_cnt++;
                if ({grant[1], busy[1], tmo[1]} !== {4'b0000, 1'b0, 1'b1}) begin
                    $display("FAIL rr_gap o%0d: got g=%b b=%b t=%b, want g=0000 b=0 t=1", o, grant[1], busy[1], tmo[1]);
                end else pass_cnt++;
                $display("rr gap after owner%0d t=%b", o % 4, tmo[1]);
            end
        end
    endtask

    task automatic test_coincidence();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        check_cnt++;
        if ({grant[1], owner[1]} !== {4'b0100, 3'd2}) begin
            $display("FAIL coin_hold: got g=%b o=%0d, want g=0100 o=2", grant[1], owner[1]);
        end else pass_cnt++;
        $display("coin hold g=%b", grant[1]);
        req = 4'b1011;
        tick();
        check_cnt++;
        if ({grant[1], busy[1], tmo[1]} !== {4'b0000, 1'b0, 1'b0}) begin
            $display("FAIL coin_release: got g=%b b=%b t=%b, want g=0000 b=0 t=0", grant[1], busy[1], tmo[1]);
        end else pass_cnt++;
        $display("coin release g=%b t=%b", grant[1], tmo[1]);
        tick();
        check_cnt++;
        if ({grant[1], owner[1]} !== {4'b1000, 3'd3}) begin
            $display("FAIL coin_next: got g=%b o=%0d, want g=1000 o=3", grant[1], owner[1]);
        end else pass_cnt++;
        $display("coin next g=%b o=%0d", grant[1], owner[1]);
    endtask

    task automatic test_turnaround();
        do_reset();
        req = 4'b0011;
        tick();
        check_cnt++;
        if (grant[2] !== 4'b0001) begin
            $display("FAIL turn_first: got g=%b, want 0001", grant[2]);
        end else pass_cnt++;
        $display("turn first g=%b", grant[2]);
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_cnt++;
            if ({grant[2], busy[2]} !== 5'b0000_0) begin
                $display("FAIL turn_gap c%0d: got g=%b b=%b, want g=0000 b=0", c, grant[2], busy[2]);
            end else pass_cnt++;
            $display("turn gap c%0d g=%b", c, grant[2]);
        end
        tick();
        check_cnt++;
        if ({grant[2], owner[2]} !== {4'b0010, 3'd1}) begin
            $display("FAIL turn_second: got g=%b o=%0d, want g=0010 o=1", grant[2], owner[2]);
        end else pass_cnt++;
        $display("turn second g=%b o=%0d", grant[2], owner[2]);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        tick();
        check_cnt++;
        if (grant[0] !== 4'b0100) begin
            $display("FAIL rstmid_pre: got g=%b, want 0100", grant[0]);
        end else pass_cnt++;
        $display("rstmid pre g=%b", grant[0]);
        rst = 1'b1;
        tick();
        check_cnt++;
        if ({grant[0], owner[0], busy[0], tmo[0]} !== 9'b0000_000_0_0) begin
            $display("FAIL rstmid_drop: got g=%b o=%0d b=%b t=%b, want zero", grant[0], owner[0], busy[0], tmo[0]);
        end else pass_cnt++;
        $display("rstmid drop g=%b o=%0d", grant[0], owner[0]);
        rst = 1'b0;
        req = 4'b1100;
        tick();
        check_cnt++;
        if ({grant[0], owner[0]} !== {4'b0100, 3'd2}) begin
            $display("FAIL rstmid_after: got g=%b o=%0d, want g=0100 o=2", grant[0], owner[0]);
        end else pass_cnt++;
        $display("rstmid after g=%b o=%0d", grant[0], owner[0]);
    endtask

    task automatic test_sole_regrant();
        do_reset();
        req = 4'b1000;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check_cnt++;
                if ({grant[3], owner[3], tmo[3]} !== {4'b1000, 3'd3, 1'b0}) begin
                    $display("FAIL sole_hold r%0d c%0d: got g=%b o=%0d t=%b, want g=1000 o=3 t=0", r, c, grant[3], owner[3], tmo[3]);
                end else pass_cnt++;
                $display("sole r%0d c%0d g=%b", r, c, grant[3]);
            end
            tick();
            check_cnt++;
            if ({grant[3], tmo[3]} !== {4'b0000, 1'b1}) begin
                $display("FAIL sole_timeout r%0d: got g=%b t=%b, want g=0000 t=1", r, grant[3], tmo[3]);
            end else pass_cnt++;
            $display("sole r%0d gap t=%b", r, tmo[3]);
        end
        tick();
        check_cnt++;
        if ({grant[3], tmo[3]} !== {4'b1000, 1'b0}) begin
            $display("FAIL sole_regrant: got g=%b t=%b, want g=1000 t=0", grant[3], tmo[3]);
        end else pass_cnt++;
        $display("sole regrant g=%b", grant[3]);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_coincidence();
        test_turnaround();
        test_reset_mid();
        test_sole_regrant();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
